// File: rtl/alu_red_if.sv
// alu_red_if -- operand/result bundle for the ALU reduction unit.
//   in_valid : operands A and B are valid this cycle
//   A, B     : 16-bit operands
//   S_RED    : registered, sign-extended byte-sum result
//   out_valid: S_RED was updated on the last clock edge
// master = producer of operands (ALU issue side / testbench)
// slave  = the reduction unit itself
interface alu_red_if;
  logic        in_valid;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] S_RED;
  logic        out_valid;

  modport master (
    output in_valid, A, B,
    input  S_RED, out_valid
  );

  modport slave (
    input  in_valid, A, B,
    output S_RED, out_valid
  );
endinterface

// File: rtl/alu_red.sv
// alu_red -- reduction ("RED") unit of the WISC CPU ALU.
// Adds the four bytes of A and B modulo 256 and sign-extends the 8-bit sum
// to 16 bits. The result is registered: one cycle of latency, qualified by
// out_valid. No backpressure; back-to-back operands give one result per cycle.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (clears S_RED and out_valid)
//   bus   : alu_red_if.slave (in_valid, A, B in; S_RED, out_valid out)
module alu_red (
  input  logic       clk,
  input  logic       rst_n,
  alu_red_if.slave   bus
);

  // 4-bit carry-lookahead block: every internal carry is formed directly
  // from generate/propagate terms and the block carry-in.
  function automatic logic [3:0] cla4_sum(input logic [3:0] a,
                                          input logic [3:0] b,
                                          input logic       c0);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return p ^ c;
  endfunction

  // Group carry of the 4-bit block: G | (P & c0).
  function automatic logic cla4_cout(input logic [3:0] a,
                                     input logic [3:0] b,
                                     input logic       c0);
    logic [3:0] g;
    logic [3:0] p;
    logic       grp_g;
    logic       grp_p;
    g     = a & b;
    p     = a ^ b;
    grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    grp_p = &p;
    return grp_g | (grp_p & c0);
  endfunction

  // Adder tree: adders 0 and 1 form level 1 (byte sums of A and B),
  // adder 2 is level 2 (sA + sB). Carries out of bit 7 are dropped, which
  // gives the mod-256 wrap at every level.
  logic [2:0][7:0] add_a;
  logic [2:0][7:0] add_b;
  logic [2:0][7:0] add_s;

  assign add_a[0] = bus.A[7:0];
  assign add_b[0] = bus.A[15:8];
  assign add_a[1] = bus.B[7:0];
  assign add_b[1] = bus.B[15:8];
  assign add_a[2] = add_s[0];
  assign add_b[2] = add_s[1];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_add8
      logic c_mid;
      assign c_mid              = cla4_cout(add_a[gi][3:0], add_b[gi][3:0], 1'b0);
      assign add_s[gi][3:0]     = cla4_sum(add_a[gi][3:0], add_b[gi][3:0], 1'b0);
      assign add_s[gi][7:4]     = cla4_sum(add_a[gi][7:4], add_b[gi][7:4], c_mid);
    end
  endgenerate

  logic [15:0] result;
  assign result = {{8{add_s[2][7]}}, add_s[2]};

  // Output register: load on in_valid, otherwise hold so don't-care
  // operands never disturb S_RED.
  logic [15:0] s_red_q;
  logic [15:0] s_red_d;
  logic        out_valid_q;
  logic        out_valid_d;

  always_comb begin
    s_red_d     = s_red_q;
    out_valid_d = 1'b0;
    if (bus.in_valid) begin
      s_red_d     = result;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_red_q     <= 16'h0000;
      out_valid_q <= 1'b0;
    end else begin
      s_red_q     <= s_red_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.S_RED     = s_red_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_red.sv
module tb_alu_red;

  logic clk;
  logic rst_n;

  alu_red_if bus ();

  alu_red dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [15:0] sb[$];

  // Reference: plain 8-bit byte sum, sign-extended.
  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
    logic [7:0] s;
    s = a[7:0] + a[15:8] + b[7:0] + b[15:8];
    return {{8{s[7]}}, s};
  endfunction

  // Drive one cycle of operands, record the expected result, step past the edge.
  task automatic apply(input logic v, input logic [15:0] a, input logic [15:0] b);
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    if (v && rst_n) sb.push_back(model(a, b));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    rst_n = 1'b1;
    apply(1'b1, 16'h1234, 16'h5678);
    exp = sb.pop_front();
    chk_cnt++;
    if (bus.S_RED !== exp || bus.out_valid !== 1'b1)
      $display("FAIL reset_precap: S_RED=%h out_valid=%b exp S_RED=%h out_valid=1", bus.S_RED, bus.out_valid, exp);
    else pass_cnt++;
    $display("reset_precap A=1234 B=5678 S_RED=%h", bus.S_RED);
    // Assert reset between edges with live operands.
    bus.in_valid = 1'b1;
    bus.A = 16'($urandom);
    bus.B = 16'($urandom);
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (bus.S_RED !== 16'h0000 || bus.out_valid !== 1'b0)
      $display("FAIL reset_async: S_RED=%h out_valid=%b exp 0000/0", bus.S_RED, bus.out_valid);
    else pass_cnt++;
    $display("reset_async S_RED=%h out_valid=%b", bus.S_RED, bus.out_valid);
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 16'($urandom), 16'($urandom));
      chk_cnt++;
      if (bus.S_RED !== 16'h0000 || bus.out_valid !== 1'b0)
        $display("FAIL reset_hold: S_RED=%h out_valid=%b exp 0000/0", bus.S_RED, bus.out_valid);
      else pass_cnt++;
      $display("reset_hold cycle %0d S_RED=%h", i, bus.S_RED);
    end
    sb.delete();
    rst_n = 1'b1;
    apply(1'b0, 16'hFFFF, 16'hFFFF);
    chk_cnt++;
    if (bus.S_RED !== 16'h0000 || bus.out_valid !== 1'b0)
      $display("FAIL reset_release: S_RED=%h out_valid=%b exp 0000/0", bus.S_RED, bus.out_valid);
    else pass_cnt++;
    $display("reset_release S_RED=%h out_valid=%b", bus.S_RED, bus.out_valid);
  endtask

  task automatic test_vectors(input string name, input logic [15:0] a,
                              input logic [15:0] b, input logic [15:0] req);
    logic [15:0] exp;
    apply(1'b1, a, b);
    chk_cnt++;
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      exp = sb.pop_front();
      if (bus.S_RED !== exp || bus.S_RED !== req || bus.out_valid !== 1'b1)
        $display("FAIL %s: S_RED=%h out_valid=%b exp S_RED=%h out_valid=1", name, bus.S_RED, bus.out_valid, req);
      else pass_cnt++;
    end
    $display("%s A=%h B=%h S_RED=%h out_valid=%b", name, a, b, bus.S_RED, bus.out_valid);
  endtask

  task automatic test_basic();
    test_vectors("zero",  16'h0000, 16'h0000, 16'h0000);
    test_vectors("basic", 16'h3524, 16'h5E81, 16'h0038);
  endtask

  task automatic test_sign_ext();
    test_vectors("sext_a", 16'h8000, 16'h0000, 16'hFF80);
    test_vectors("sext_b", 16'h7F00, 16'h0001, 16'hFF80);
  endtask

  task automatic test_wrap();
    test_vectors("wrap_ff",  16'hFFFF, 16'hFFFF, 16'hFFFC);
    test_vectors("wrap_100", 16'h0101, 16'h7F7F, 16'h0000);
  endtask

  task automatic test_hold();
    test_vectors("hold_cap", 16'h0102, 16'h0304, 16'h000A);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 16'hFFFF, 16'($urandom));
      chk_cnt++;
      if (bus.S_RED !== 16'h000A || bus.out_valid !== 1'b0)
        $display("FAIL hold: S_RED=%h out_valid=%b exp 000A/0", bus.S_RED, bus.out_valid);
      else pass_cnt++;
      $display("hold cycle %0d S_RED=%h out_valid=%b", i, bus.S_RED, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      apply(1'b1, a, b);
      chk_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL stream[%0d]: scoreboard empty", i);
      end else begin
        exp = sb.pop_front();
        if (bus.S_RED !== exp || bus.out_valid !== 1'b1)
          $display("FAIL stream[%0d]: A=%h B=%h S_RED=%h out_valid=%b exp S_RED=%h out_valid=1",
                   i, a, b, bus.S_RED, bus.out_valid, exp);
        else pass_cnt++;
      end
      $display("stream[%0d] A=%h B=%h S_RED=%h", i, a, b, bus.S_RED);
      if (i == 500) begin
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (bus.S_RED !== 16'h0000 || bus.out_valid !== 1'b0)
          $display("FAIL stream_reset: S_RED=%h out_valid=%b exp 0000/0", bus.S_RED, bus.out_valid);
        else pass_cnt++;
        $display("stream_reset S_RED=%h out_valid=%b", bus.S_RED, bus.out_valid);
        sb.delete();
        rst_n = 1'b1;
      end
    end
    chk_cnt++;
    if (sb.size() != 0)
      $display("FAIL stream_drain: %0d results left, exp 0", sb.size());
    else pass_cnt++;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.A        = 16'($urandom);
    bus.B        = 16'($urandom);
    #1;
    chk_cnt++;
    if (bus.S_RED !== 16'h0000 || bus.out_valid !== 1'b0)
      $display("FAIL reset_init: S_RED=%h out_valid=%b exp 0000/0", bus.S_RED, bus.out_valid);
    else pass_cnt++;
    $display("reset_init S_RED=%h out_valid=%b", bus.S_RED, bus.out_valid);
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_sign_ext();
    test_wrap();
    test_hold();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_red.md
Name: alu_red

Overview:
- Reduction ("RED") unit of the WISC CPU ALU.
- Sums the four bytes of two 16-bit operands modulo 256 and sign-extends the 8-bit sum to 16 bits.
- Output is registered: one cycle of latency, qualified by a valid strobe. It sits beside the other ALU function units and is selected by the ALU result mux.

Parameters:
- none; all widths are fixed at 16-bit operands and an 8-bit internal sum.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  A and B are valid this cycle; capture the result.
- A  input  16  operand A.
- B  input  16  operand B.
- S_RED  output  16  registered reduction result.
- out_valid  output  1  S_RED was updated on the last clock edge.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Arithmetic, combinational stage:
  - sA = (A[7:0] + A[15:8]) mod 256.
  - sB = (B[7:0] + B[15:8]) mod 256.
  - sum = (sA + sB) mod 256.
  - All carries out of bit 7 are discarded at every level.
  - Result = {8{sum[7]}, sum[7:0]}: the sum is treated as a signed 8-bit value and sign-extended.
- Adder structure: two-level tree built from 8-bit adders made of two cascaded 4-bit carry-lookahead blocks (generate/propagate per bit, group carry). Level 1 computes sA and sB in parallel. Level 2 computes sum. No overflow or saturation detection; wrap-around is the defined behaviour.
- Registered stage:
  - On a rising clk with in_valid=1: S_RED <= result, out_valid <= 1.
  - On a rising clk with in_valid=0: S_RED holds its previous value, out_valid <= 0.
  - Latency is exactly 1 cycle. Back-to-back in_valid gives one result per cycle; there is no backpressure.
- Reset:
  - rst_n low immediately forces S_RED=16'h0000 and out_valid=0, independent of clk.
  - While rst_n is low, in_valid is ignored.
  - Reset asserted mid-stream discards any pending capture.
  - The first capture after deassertion occurs on the first rising edge with rst_n high and in_valid=1.
- X handling: A and B are don't-care when in_valid=0; S_RED must not change in that case.

Test Plan:
1. Reset: assert rst_n=0 with random A/B and in_valid=1 -> S_RED=0x0000 and out_valid=0 asynchronously; both remain so until rst_n=1 and a clock edge arrives.
2. Zero and basic: A=0x0000, B=0x0000, in_valid=1 -> next cycle S_RED=0x0000, out_valid=1. Then A=0x3524, B=0x5E81 -> (0x59+0xDF) mod 256 = 0x38, so S_RED=0x0038.
3. Sign extension: A=0x8000, B=0x0000 -> S_RED=0xFF80. A=0x7F00, B=0x0001 -> 0x80, so S_RED=0xFF80.
4. Wrap-around: A=0xFFFF, B=0xFFFF -> 0x3FC mod 256 = 0xFC, so S_RED=0xFFFC. A=0x0101, B=0x7F7F -> 0x100 mod 256, so S_RED=0x0000.
5. Hold and valid: capture A=0x0102, B=0x0304 (S_RED=0x000A). Then drive in_valid=0 with A=0xFFFF for 3 cycles -> S_RED stays 0x000A and out_valid=0.
6. Streaming plus random: 1000 back-to-back random A/B with in_valid=1 -> every cycle S_RED matches the sign-extended mod-256 byte-sum model of the previous cycle's inputs. Include one mid-stream async reset pulse, which must clear S_RED and out_valid at once.
